// File: rtl/vending_machine_param.sv
// vending_machine_param
//   Parametrised coin-operated vending machine with NUM_ITEMS slots, each with
//   its own price and stock. Idle display modes (price / qty / revenue / update)
//   are chosen by {admin,info}. Coins move the machine into BUY. A buy then
//   dispenses through VEND, and any remaining credit is returned through CHANGE.
//
//   All coin, buy and cancel inputs act only on a registered 0->1 transition.
//   All outputs are registered. output_money shows the value of the state being
//   entered, so it lines up with output_state.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   item                     selected item index
//   nickel/dime/quarter      coin inputs (5/10/25 cents)
//   buy                      purchase request; table write strobe in UPDATE
//   cancel                   refund request
//   admin, info              idle mode select
//   upd_price, upd_qty       table write data used in UPDATE
//   output_state             current state code (also the FSM debug view)
//   output_money             displayed value
//   vend_valid/vend_item     one-cycle dispense pulse and dispensed item
//   change_valid/amount      one-cycle refund pulse and refunded amount
//   coin_reject              one-cycle pulse when a coin would exceed MAX_CREDIT
//   error                    one-cycle pulse on sold-out or insufficient credit
//
// Handshake: vend_valid and change_valid are single-cycle strobes. There is no
// ready input. vend_item and change_amount are meaningful only while their
// strobe is high.
module vending_machine_param #(
  parameter int NUM_ITEMS     = 4,
  parameter int ITEM_W        = 2,
  parameter int MONEY_W       = 7,
  parameter int QTY_W         = 4,
  parameter int REV_W         = 12,
  parameter int MAX_CREDIT    = 100,
  parameter int PRICE_DEFAULT = 35,
  parameter int QTY_DEFAULT   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ITEM_W-1:0]  item,
  input  logic               nickel,
  input  logic               dime,
  input  logic               quarter,
  input  logic               buy,
  input  logic               cancel,
  input  logic               admin,
  input  logic               info,
  input  logic [MONEY_W-1:0] upd_price,
  input  logic [QTY_W-1:0]   upd_qty,
  output logic [2:0]         output_state,
  output logic [MONEY_W-1:0] output_money,
  output logic               vend_valid,
  output logic [ITEM_W-1:0]  vend_item,
  output logic               change_valid,
  output logic [MONEY_W-1:0] change_amount,
  output logic               coin_reject,
  output logic               error
);

  typedef enum logic [2:0] {
    S_PRICE   = 3'b000,
    S_QTY     = 3'b001,
    S_REVENUE = 3'b010,
    S_UPDATE  = 3'b011,
    S_BUY     = 3'b100,
    S_VEND    = 3'b101,
    S_CHANGE  = 3'b110
  } state_t;

  state_t              state, state_d, mode_state;
  logic [MONEY_W-1:0]  credit, credit_d;
  logic [REV_W-1:0]    revenue, revenue_d;
  logic [MONEY_W-1:0]  price [NUM_ITEMS];
  logic [QTY_W-1:0]    qty   [NUM_ITEMS];

  logic nickel_q, dime_q, quarter_q, buy_q, cancel_q;
  logic nickel_edge, dime_edge, quarter_edge, buy_edge, cancel_edge, coin_edge;

  logic [MONEY_W-1:0]  coin_val;
  logic [MONEY_W:0]    credit_sum;
  logic                coin_fits;
  logic [MONEY_W-1:0]  cur_price, vend_price, money_d, change_amount_d;
  logic [QTY_W-1:0]    cur_qty;
  logic [REV_W:0]      rev_sum;
  logic [ITEM_W-1:0]   vend_item_d;
  logic                reject_d, error_d, tbl_we, qty_dec;

  assign output_state = state;

  assign nickel_edge  = nickel  & ~nickel_q;
  assign dime_edge    = dime    & ~dime_q;
  assign quarter_edge = quarter & ~quarter_q;
  assign buy_edge     = buy     & ~buy_q;
  assign cancel_edge  = cancel  & ~cancel_q;
  assign coin_edge    = nickel_edge | dime_edge | quarter_edge;

  // Only the most valuable simultaneous coin edge is evaluated.
  always_comb begin
    coin_val = '0;
    if (quarter_edge)     coin_val = MONEY_W'(25);
    else if (dime_edge)   coin_val = MONEY_W'(10);
    else if (nickel_edge) coin_val = MONEY_W'(5);
  end

  assign credit_sum = {1'b0, credit} + {1'b0, coin_val};
  assign coin_fits  = (credit_sum <= (MONEY_W+1)'(MAX_CREDIT));
  assign cur_price  = price[item];
  assign cur_qty    = qty[item];
  assign vend_price = price[vend_item];
  assign rev_sum    = {1'b0, revenue} + (REV_W+1)'(vend_price);

  always_comb begin
    case ({admin, info})
      2'b00:   mode_state = S_PRICE;
      2'b01:   mode_state = S_QTY;
      2'b10:   mode_state = S_REVENUE;
      default: mode_state = S_UPDATE;
    endcase
  end

  always_comb begin
    state_d         = state;
    credit_d        = credit;
    revenue_d       = revenue;
    vend_item_d     = vend_item;
    change_amount_d = change_amount;
    reject_d        = 1'b0;
    error_d         = 1'b0;
    tbl_we          = 1'b0;
    qty_dec         = 1'b0;
    case (state)
      S_PRICE, S_QTY: begin
        state_d = mode_state;
        if (coin_edge) begin
          if (coin_fits) begin
            credit_d = credit_sum[MONEY_W-1:0];
            state_d  = S_BUY;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_REVENUE: state_d = mode_state;
      S_UPDATE: begin
        state_d = mode_state;
        tbl_we  = buy_edge;
      end
      S_BUY: begin
        // cancel > buy > coin; lower-priority edges this cycle are dropped.
        if (cancel_edge) begin
          change_amount_d = credit;
          state_d         = S_CHANGE;
        end else if (buy_edge) begin
          if (cur_qty == '0 || credit < cur_price) begin
            error_d = 1'b1;
          end else begin
            vend_item_d = item;
            state_d     = S_VEND;
          end
        end else if (coin_edge) begin
          if (coin_fits) credit_d = credit_sum[MONEY_W-1:0];
          else           reject_d = 1'b1;
        end
      end
      S_VEND: begin
        qty_dec   = 1'b1;
        revenue_d = rev_sum[REV_W] ? '1 : rev_sum[REV_W-1:0];
        // The buy check guarantees credit >= price, so this cannot underflow.
        credit_d  = credit - vend_price;
        if (credit_d != '0) begin
          change_amount_d = credit_d;
          state_d         = S_CHANGE;
        end else begin
          state_d = S_PRICE;
        end
      end
      S_CHANGE: begin
        credit_d = '0;
        state_d  = S_PRICE;
      end
      default: state_d = S_PRICE;
    endcase
  end

  // Display value for the state being entered.
  always_comb begin
    case (state_d)
      S_PRICE, S_UPDATE: money_d = cur_price;
      S_QTY:             money_d = MONEY_W'(cur_qty);
      S_REVENUE:         money_d = revenue_d[MONEY_W-1:0];
      default:           money_d = credit_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_PRICE;
      credit        <= '0;
      revenue       <= '0;
      nickel_q      <= 1'b0;
      dime_q        <= 1'b0;
      quarter_q     <= 1'b0;
      buy_q         <= 1'b0;
      cancel_q      <= 1'b0;
      output_money  <= MONEY_W'(PRICE_DEFAULT);
      vend_valid    <= 1'b0;
      vend_item     <= '0;
      change_valid  <= 1'b0;
      change_amount <= '0;
      coin_reject   <= 1'b0;
      error         <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        price[i] <= MONEY_W'(PRICE_DEFAULT);
        qty[i]   <= QTY_W'(QTY_DEFAULT);
      end
    end else begin
      state         <= state_d;
      credit        <= credit_d;
      revenue       <= revenue_d;
      nickel_q      <= nickel;
      dime_q        <= dime;
      quarter_q     <= quarter;
      buy_q         <= buy;
      cancel_q      <= cancel;
      output_money  <= money_d;
      vend_valid    <= (state_d == S_VEND);
      vend_item     <= vend_item_d;
      change_valid  <= (state_d == S_CHANGE);
      change_amount <= change_amount_d;
      coin_reject   <= reject_d;
      error         <= error_d;
      if (tbl_we) begin
        price[item] <= upd_price;
        qty[item]   <= upd_qty;
      end
      if (qty_dec && qty[vend_item] != '0)
        qty[vend_item] <= qty[vend_item] - QTY_W'(1);
    end
  end

endmodule

// File: tb/tb_vending_machine_param.sv
module tb_vending_machine_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] item;
  logic       nickel, dime, quarter, buy, cancel, admin, info;
  logic [6:0] upd_price;
  logic [3:0] upd_qty;
  logic [2:0] output_state;
  logic [6:0] output_money;
  logic       vend_valid;
  logic [1:0] vend_item;
  logic       change_valid;
  logic [6:0] change_amount;
  logic       coin_reject;
  logic       error;

  // clock / reset
  always #5 clk = ~clk;

  vending_machine_param dut (
    .clk(clk), .rst(rst), .item(item),
    .nickel(nickel), .dime(dime), .quarter(quarter),
    .buy(buy), .cancel(cancel), .admin(admin), .info(info),
    .upd_price(upd_price), .upd_qty(upd_qty),
    .output_state(output_state), .output_money(output_money),
    .vend_valid(vend_valid), .vend_item(vend_item),
    .change_valid(change_valid), .change_amount(change_amount),
    .coin_reject(coin_reject), .error(error)
  );

  typedef struct {
    logic [1:0] item;
    logic [2:0] coins;   // {quarter, dime, nickel}
    logic       buy;
    logic       cancel;
    logic [1:0] mode;    // {admin, info}
    logic [2:0] st;
    logic [6:0] money;
    logic       vv;
    logic [1:0] vi;
    logic       cv;
    logic [6:0] ca;
    logic       rej;
    logic       err;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   vec_no = 0;
  logic [22:0] exp_q[$];
  vec_t vecs[$];

  // vend_item / change_amount only carry meaning alongside their strobes.
  function automatic logic [22:0] pack_out(logic [2:0] st, logic [6:0] m, logic vv,
                                           logic [1:0] vi, logic cv, logic [6:0] ca,
                                           logic rej, logic er);
    return {st, m, vv, (vv ? vi : 2'b00), cv, (cv ? ca : 7'd0), rej, er};
  endfunction

  function automatic vec_t mkv(int it, int co, int b, int c, int md, int st, int m,
                               int vv, int vi, int cv, int ca, int rej, int er);
    vec_t v;
    v.item = 2'(it); v.coins = 3'(co); v.buy = 1'(b); v.cancel = 1'(c);
    v.mode = 2'(md); v.st = 3'(st); v.money = 7'(m); v.vv = 1'(vv);
    v.vi = 2'(vi); v.cv = 1'(cv); v.ca = 7'(ca); v.rej = 1'(rej); v.err = 1'(er);
    return v;
  endfunction

  // short form for vectors with no strobes
  task automatic add(int it, int co, int b, int c, int md, int st, int m);
    vecs.push_back(mkv(it, co, b, c, md, st, m, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic addx(int it, int co, int b, int c, int md, int st, int m,
                      int vv, int vi, int cv, int ca, int rej, int er);
    vecs.push_back(mkv(it, co, b, c, md, st, m, vv, vi, cv, ca, rej, er));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // driver + scoreboard: push expectation, clock, pop and compare
  task automatic apply(input vec_t v);
    logic [22:0] got, exp;
    item    = v.item;
    quarter = v.coins[2];
    dime    = v.coins[1];
    nickel  = v.coins[0];
    buy     = v.buy;
    cancel  = v.cancel;
    admin   = v.mode[1];
    info    = v.mode[0];
    exp_q.push_back(pack_out(v.st, v.money, v.vv, v.vi, v.cv, v.ca, v.rej, v.err));
    tick();
    vec_no++;
    got = pack_out(output_state, output_money, vend_valid, vend_item,
                   change_valid, change_amount, coin_reject, error);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL vec%0d: scoreboard queue empty", vec_no);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL vec%0d: got st=%0d money=%0d vv=%0b vi=%0d cv=%0b ca=%0d rej=%0b err=%0b; want st=%0d money=%0d vv=%0b vi=%0d cv=%0b ca=%0d rej=%0b err=%0b",
                 vec_no, got[22:20], got[19:13], got[12], got[11:10], got[9], got[8:2], got[1], got[0],
                 exp[22:20], exp[19:13], exp[12], exp[11:10], exp[9], exp[8:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic run_table;
    while (vecs.size() != 0) apply(vecs.pop_front());
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst = 1'b1; item = 2'd2; nickel = 0; dime = 0; quarter = 0;
    buy = 0; cancel = 0; admin = 0; info = 0;
    upd_price = 7'd60; upd_qty = 4'd9;

    // reset state
    apply(mkv(2, 0, 0, 0, 0, 0, 35, 0, 0, 0, 0, 0, 0));
    apply(mkv(2, 0, 0, 0, 0, 0, 35, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    // display modes
    add(2, 0, 0, 0, 0, 0, 35);
    add(2, 0, 0, 0, 1, 1, 2);
    add(2, 0, 0, 0, 2, 2, 0);
    // coins and a purchase with change
    add(1, 0, 0, 0, 0, 0, 35);
    add(1, 1, 0, 0, 0, 4, 5);
    add(1, 0, 0, 0, 0, 4, 5);
    add(1, 1, 0, 0, 0, 4, 10);
    add(1, 2, 0, 0, 0, 4, 20);
    add(1, 4, 0, 0, 0, 4, 45);
    add(1, 0, 0, 0, 0, 4, 45);
    addx(1, 0, 1, 0, 0, 5, 45, 1, 1, 0, 0, 0, 0);
    addx(1, 0, 0, 0, 0, 6, 10, 0, 0, 1, 10, 0, 0);
    add(1, 0, 0, 0, 0, 0, 35);
    add(1, 0, 0, 0, 1, 1, 1);
    add(1, 0, 0, 0, 2, 2, 35);
    add(1, 0, 0, 0, 0, 0, 35);
    // exact change, then sold out
    add(1, 2, 0, 0, 0, 4, 10);
    add(1, 4, 0, 0, 0, 4, 35);
    add(1, 0, 0, 0, 0, 4, 35);
    addx(1, 0, 1, 0, 0, 5, 35, 1, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 35);
    add(1, 0, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 35);
    add(1, 2, 0, 0, 0, 4, 10);
    add(1, 4, 0, 0, 0, 4, 35);
    add(1, 0, 0, 0, 0, 4, 35);
    addx(1, 0, 1, 0, 0, 4, 35, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 4, 35);
    addx(1, 0, 0, 1, 0, 6, 35, 0, 0, 1, 35, 0, 0);
    add(1, 0, 0, 0, 0, 0, 35);
    add(1, 0, 0, 0, 2, 2, 70);
    add(1, 0, 0, 0, 0, 0, 35);
    // insufficient credit, cancel beats buy, simultaneous coins
    add(0, 4, 0, 0, 0, 4, 25);
    add(0, 0, 0, 0, 0, 4, 25);
    addx(0, 0, 1, 0, 0, 4, 25, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 4, 25);
    addx(0, 0, 1, 1, 0, 6, 25, 0, 0, 1, 25, 0, 0);
    add(0, 0, 0, 0, 0, 0, 35);
    add(0, 7, 0, 0, 0, 4, 25);
    add(0, 0, 0, 0, 0, 4, 25);
    addx(0, 0, 0, 1, 0, 6, 25, 0, 0, 1, 25, 0, 0);
    add(0, 0, 0, 0, 0, 0, 35);
    // credit saturation
    add(0, 4, 0, 0, 0, 4, 25);
    add(0, 0, 0, 0, 0, 4, 25);
    add(0, 4, 0, 0, 0, 4, 50);
    add(0, 0, 0, 0, 0, 4, 50);
    add(0, 4, 0, 0, 0, 4, 75);
    add(0, 0, 0, 0, 0, 4, 75);
    add(0, 4, 0, 0, 0, 4, 100);
    add(0, 0, 0, 0, 0, 4, 100);
    addx(0, 4, 0, 0, 0, 4, 100, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 4, 100);
    addx(0, 0, 0, 1, 0, 6, 100, 0, 0, 1, 100, 0, 0);
    add(0, 0, 0, 0, 0, 0, 35);
    run_table();

    // nickel held high for 20 cycles counts once
    for (int i = 0; i < 20; i++)
      apply(mkv(0, 1, 0, 0, 0, 4, 5, 0, 0, 0, 0, 0, 0));
    apply(mkv(0, 0, 0, 1, 0, 6, 5, 0, 0, 1, 5, 0, 0));
    apply(mkv(0, 0, 0, 0, 0, 0, 35, 0, 0, 0, 0, 0, 0));

    // table update; coin ignored in UPDATE
    add(3, 0, 0, 0, 3, 3, 35);
    add(3, 0, 1, 0, 3, 3, 35);
    add(3, 0, 0, 0, 3, 3, 60);
    add(3, 4, 0, 0, 3, 3, 60);
    add(3, 0, 0, 0, 3, 3, 60);
    add(3, 0, 0, 0, 0, 0, 60);
    add(3, 0, 0, 0, 1, 1, 9);
    add(3, 0, 0, 0, 0, 0, 60);
    // build 45 credit on item 1 before resetting
    add(1, 4, 0, 0, 0, 4, 25);
    add(1, 0, 0, 0, 0, 4, 25);
    add(1, 2, 0, 0, 0, 4, 35);
    add(1, 0, 0, 0, 0, 4, 35);
    add(1, 2, 0, 0, 0, 4, 45);
    run_table();

    // reset mid-transaction: no change pulse, tables restored
    rst = 1'b1;
    apply(mkv(1, 0, 0, 0, 0, 0, 35, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    apply(mkv(1, 0, 0, 0, 0, 0, 35, 0, 0, 0, 0, 0, 0));
    apply(mkv(3, 0, 0, 0, 0, 0, 35, 0, 0, 0, 0, 0, 0));
    apply(mkv(3, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0));
    apply(mkv(1, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
